mem_stage: RTL and testbench



---
 rtl/mem_stage_pkg.sv | 42 ++++
 rtl/mem_stage_load_extend.sv | 22 ++
 rtl/mem_stage.sv | 143 ++++++++++++++
 tb/tb_mem_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: access type codes, FSM states and byte counts.
package mem_stage_pkg;

  // Load/store access type codes as driven by the decode/EX stages.
  typedef enum logic [3:0] {
    LsLb  = 4'd0,
    LsLh  = 4'd1,
    LsLw  = 4'd2,
    LsLbu = 4'd3,
    LsLhu = 4'd4,
    LsSb  = 4'd5,
    LsSh  = 4'd6,
    LsSw  = 4'd7
  } ls_type_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } mem_state_e;

  localparam logic [2:0] NBytesB = 3'd1;
  localparam logic [2:0] NBytesH = 3'd2;
  localparam logic [2:0] NBytesW = 3'd4;

  // Codes above LsSw are not memory operations.
  function automatic logic ls_known(input logic [3:0] ls_type);
    return ls_type <= LsSw;
  endfunction

  function automatic logic [2:0] ls_nbytes(input logic [3:0] ls_type);
    logic [2:0] n;
    case (ls_type)
      LsLb, LsLbu, LsSb: n = NBytesB;
      LsLh, LsLhu, LsSh: n = NBytesH;
      LsLw, LsSw:        n = NBytesW;
      default:           n = NBytesB;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Sign/zero extension of the assembled little-endian load buffer by access type.
module mem_stage_load_extend
  import mem_stage_pkg::*;
(
  input  logic [3:0]  load_store_type_i,
  input  logic [31:0] buf_i,
  output logic [31:0] data_o
);

  // Select extension from the type code; full words pass unchanged.
  always_comb begin
    data_o = buf_i;
    case (load_store_type_i)
      LsLb:    data_o = {{24{buf_i[7]}}, buf_i[7:0]};
      LsLbu:   data_o = {24'h000000, buf_i[7:0]};
      LsLh:    data_o = {{16{buf_i[15]}}, buf_i[15:0]};
      LsLhu:   data_o = {16'h0000, buf_i[15:0]};
      default: data_o = buf_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: passes non-memory results through and serialises loads/stores
// into byte transfers on the 8-bit memory-controller port, stalling until done.
// Optional: define MEM_MISALIGN_CHECK_EN to reject misaligned halfword/word accesses.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              rd_enable_i,
  input  logic              load_enable_i,
  input  logic              store_enable_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [3:0]        load_store_type_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [4:0]        rd_addr_o,
  output logic              rd_enable_o,
  output logic              mc_req_o,
  output logic              mc_we_o,
  output logic [ADDR_W-1:0] mc_addr_o,
  output logic [7:0]        mc_wdata_o,
  input  logic [7:0]        mc_rdata_i,
  input  logic              mc_ready_i,
  output logic              stall_req_o,
  output logic              misalign_o
);

  mem_state_e        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [DATA_W-1:0] ext_data;
  logic              is_store, is_load, mem_op, last_byte, misaligned;
  logic [2:0]        nbytes;

  // A store wins when both enables are set; unknown codes are plain pass-through ops.
  assign is_store  = store_enable_i && ls_known(load_store_type_i);
  assign is_load   = load_enable_i && !store_enable_i && ls_known(load_store_type_i);
  assign mem_op    = is_store || is_load;
  assign nbytes    = ls_nbytes(load_store_type_i);
  assign last_byte = ({1'b0, cnt_q} == (nbytes - 3'd1));

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned = ((nbytes == NBytesH) && mem_addr_i[0]) ||
                      ((nbytes == NBytesW) && (mem_addr_i[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  mem_stage_load_extend u_load_extend (
    .load_store_type_i (load_store_type_i),
    .buf_i             (buf_q),
    .data_o            (ext_data)
  );

  // State, byte counter and load assembly buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  // Next-state: one byte per mc_ready_i in BUSY, a single DONE cycle, then back to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = 2'd0;
        buf_d = '0;
        if (mem_op) begin
          state_d = misaligned ? StDone : StBusy;
        end
      end
      StBusy: begin
        if (mc_ready_i) begin
          buf_d[{cnt_q, 3'b000} +: 8] = mc_rdata_i;
          if (last_byte) begin
            state_d = StDone;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = 2'd0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // Outputs: writeback is suppressed while stalled; DONE presents the extended load.
  always_comb begin
    rd_data_o   = rd_data_i;
    rd_addr_o   = rd_addr_i;
    rd_enable_o = rd_enable_i;
    mc_req_o    = 1'b0;
    mc_we_o     = 1'b0;
    mc_addr_o   = mem_addr_i + ADDR_W'(cnt_q);
    mc_wdata_o  = rd_data_i[{cnt_q, 3'b000} +: 8];
    stall_req_o = 1'b0;
    misalign_o  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_op) begin
          stall_req_o = 1'b1;
          rd_enable_o = 1'b0;
        end
      end
      StBusy: begin
        mc_req_o    = 1'b1;
        mc_we_o     = is_store;
        stall_req_o = 1'b1;
        rd_enable_o = 1'b0;
      end
      StDone: begin
        misalign_o = misaligned;
        if (is_store || misaligned) begin
          rd_enable_o = 1'b0;
        end else if (is_load) begin
          rd_data_o = ext_data;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized operations
// compared cycle by cycle against a transaction-level reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rd_data_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        rd_enable_i = 1'b0;
  logic        load_enable_i = 1'b0;
  logic        store_enable_i = 1'b0;
  logic [31:0] mem_addr_i = '0;
  logic [3:0]  load_store_type_i = '0;
  logic [31:0] rd_data_o;
  logic [4:0]  rd_addr_o;
  logic        rd_enable_o;
  logic        mc_req_o;
  logic        mc_we_o;
  logic [31:0] mc_addr_o;
  logic [7:0]  mc_wdata_o;
  logic [7:0]  mc_rdata_i = '0;
  logic        mc_ready_i = 1'b0;
  logic        stall_req_o;
  logic        misalign_o;

  always #5 clk = ~clk;

  mem_stage #(
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .rd_data_i         (rd_data_i),
    .rd_addr_i         (rd_addr_i),
    .rd_enable_i       (rd_enable_i),
    .load_enable_i     (load_enable_i),
    .store_enable_i    (store_enable_i),
    .mem_addr_i        (mem_addr_i),
    .load_store_type_i (load_store_type_i),
    .rd_data_o         (rd_data_o),
    .rd_addr_o         (rd_addr_o),
    .rd_enable_o       (rd_enable_o),
    .mc_req_o          (mc_req_o),
    .mc_we_o           (mc_we_o),
    .mc_addr_o         (mc_addr_o),
    .mc_wdata_o        (mc_wdata_o),
    .mc_rdata_i        (mc_rdata_i),
    .mc_ready_i        (mc_ready_i),
    .stall_req_o       (stall_req_o),
    .misalign_o        (misalign_o)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: byte count and extension from the type rules, in plain arithmetic.
  function automatic int nbytes_of(input int t);
    if (t == 0 || t == 3 || t == 5) return 1;
    if (t == 1 || t == 4 || t == 6) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] extend_of(input int t, input logic [31:0] raw);
    if (t == 0 && raw >= 32'd128) return raw + 32'hFFFFFF00;
    if (t == 1 && raw >= 32'd32768) return raw + 32'hFFFF0000;
    return raw;
  endfunction

  function automatic bit model_misaligned(input int n, input logic [31:0] a);
`ifdef MEM_MISALIGN_CHECK_EN
    return (a % n) != 0;
`else
    return (n < 0) && (a == 0);
`endif
  endfunction

  // One load/store. waits holds the number of not-ready cycles before byte k in nibble k;
  // rword supplies the read bytes little-endian. pre_applied skips the IDLE cycle.
  task automatic run_op(input bit ld, input bit st, input int typ, input logic [31:0] addr,
                        input logic [31:0] data, input logic [4:0] ra, input bit ren,
                        input logic [31:0] rword, input logic [15:0] waits,
                        input bit pre_applied);
    int          n;
    int          nw;
    bit          mis;
    logic [31:0] raw;
    n   = nbytes_of(typ);
    mis = model_misaligned(n, addr);
    raw = (n == 4) ? rword : (rword % (32'd1 << (8 * n)));
    if (!pre_applied) begin
      @(posedge clk); #1;
      load_enable_i     = ld;
      store_enable_i    = st;
      load_store_type_i = 4'(typ);
      mem_addr_i        = addr;
      rd_data_i         = data;
      rd_addr_i         = ra;
      rd_enable_i       = ren;
      mc_ready_i        = 1'($urandom_range(0, 1));
      mc_rdata_i        = 8'($urandom);
      @(negedge clk);
      check_eq("idle_stall", stall_req_o, 1);
      check_eq("idle_req", mc_req_o, 0);
      check_eq("idle_rden", rd_enable_o, 0);
    end
    if (!mis) begin
      for (int k = 0; k < n; k++) begin
        nw = int'((waits >> (4 * k)) & 16'hF);
        for (int w = 0; w <= nw; w++) begin
          @(posedge clk); #1;
          mc_ready_i = (w == nw);
          mc_rdata_i = (w == nw) ? rword[8 * k +: 8] : 8'($urandom);
          @(negedge clk);
          check_eq("busy_req", mc_req_o, 1);
          check_eq("busy_addr", mc_addr_o, addr + 32'(k));
          check_eq("busy_we", mc_we_o, {31'd0, st});
          if (st) check_eq("busy_wdata", mc_wdata_o, (data >> (8 * k)) & 32'hFF);
          check_eq("busy_stall", stall_req_o, 1);
          check_eq("busy_rden", rd_enable_o, 0);
          check_eq("busy_misalign", misalign_o, 0);
        end
      end
    end
    @(posedge clk); #1;
    mc_ready_i = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_eq("done_stall", stall_req_o, 0);
    check_eq("done_req", mc_req_o, 0);
    check_eq("done_misalign", misalign_o, {31'd0, mis});
    check_eq("done_rdaddr", rd_addr_o, {27'd0, ra});
    check_eq("done_rden", rd_enable_o, (st || mis) ? 32'd0 : {31'd0, ren});
    if (!st && !mis) check_eq("done_rddata", rd_data_o, extend_of(typ, raw));
  endtask

  task automatic run_nonmem(input bit ld, input bit st, input int typ, input logic [31:0] data,
                            input logic [4:0] ra, input bit ren);
    @(posedge clk); #1;
    load_enable_i     = ld;
    store_enable_i    = st;
    load_store_type_i = 4'(typ);
    mem_addr_i        = $urandom;
    rd_data_i         = data;
    rd_addr_i         = ra;
    rd_enable_i       = ren;
    mc_ready_i        = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_eq("pass_data", rd_data_o, data);
    check_eq("pass_addr", rd_addr_o, {27'd0, ra});
    check_eq("pass_en", rd_enable_o, {31'd0, ren});
    check_eq("pass_stall", stall_req_o, 0);
    check_eq("pass_req", mc_req_o, 0);
    check_eq("pass_misalign", misalign_o, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          r;
    int          typ;
    bit          ld;
    bit          st;
    logic [31:0] addr;

    // Reset with a non-memory op on the inputs
    rd_data_i   = 32'hCAFEF00D;
    rd_addr_i   = 5'd9;
    rd_enable_i = 1'b1;
    mc_ready_i  = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_req", mc_req_o, 0);
    check_eq("rst_stall", stall_req_o, 0);
    check_eq("rst_misalign", misalign_o, 0);
    check_eq("rst_rddata", rd_data_o, 32'hCAFEF00D);
    check_eq("rst_rden", rd_enable_o, 1);

    run_nonmem(1'b0, 1'b0, 0, 32'h12345678, 5'd5, 1'b1);
    run_op(1'b1, 1'b0, 0, 32'h100, 32'h0, 5'd3, 1'b1, 32'h00000080, 16'h0000, 1'b0);
    run_op(1'b1, 1'b0, 2, 32'h200, 32'h0, 5'd4, 1'b1, 32'h44332211, 16'h0200, 1'b0);
    run_op(1'b0, 1'b1, 6, 32'hFFFFFFFF, 32'h0000ABCD, 5'd6, 1'b1, 32'h0, 16'h0000, 1'b0);
    run_op(1'b1, 1'b0, 4, 32'h40, 32'h0, 5'd7, 1'b1, 32'h0000F00F, 16'h0010, 1'b0);

    // Reset after two bytes of a word load, then the same load restarts from byte 0
    @(posedge clk); #1;
    load_enable_i     = 1'b1;
    store_enable_i    = 1'b0;
    load_store_type_i = 4'd2;
    mem_addr_i        = 32'h300;
    rd_addr_i         = 5'd8;
    rd_enable_i       = 1'b1;
    mc_ready_i        = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      mc_ready_i = 1'b1;
      mc_rdata_i = 8'($urandom);
      @(negedge clk);
      check_eq("pre_rst_addr", mc_addr_o, 32'h300 + 32'(k));
    end
    @(posedge clk); #1;
    mc_ready_i = 1'b0;
    rst        = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_req", mc_req_o, 0);
    check_eq("post_rst_stall", stall_req_o, 1);
    check_eq("post_rst_rden", rd_enable_o, 0);
    run_op(1'b1, 1'b0, 2, 32'h300, 32'h0, 5'd8, 1'b1, 32'h8899AABB, 16'h0000, 1'b1);

    // Misaligned word load (rejected when the check is built in)
    run_op(1'b1, 1'b0, 2, 32'h102, 32'h0, 5'd2, 1'b1, 32'hDEADBEEF, 16'h0000, 1'b0);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        run_nonmem(1'b0, 1'b0, $urandom_range(0, 15), $urandom, 5'($urandom), 1'($urandom));
      end else if (r == 1) begin
        run_nonmem(1'b1, 1'($urandom), $urandom_range(8, 15), $urandom, 5'($urandom),
                   1'($urandom));
      end else begin
        typ  = $urandom_range(0, 7);
        st   = (typ >= 5);
        ld   = !st || ($urandom_range(0, 3) == 0);
        addr = (r == 2) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3)) : $urandom;
        run_op(ld, st, typ, addr, $urandom, 5'($urandom), 1'($urandom), $urandom,
               16'($urandom & $urandom & 32'h3333), 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
